// File: rtl/button_conditioner.sv
// button_conditioner: four independent push-button channels, each with a
// two-flop synchronizer, a debounce counter and a press/release FSM.
// Produces debounced levels and a registered one-cycle pulse per accepted press.
module button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic       clk,
   input  logic       btnc,
   input  logic       btnu,
   input  logic       btnd,
   input  logic       btnl,
   input  logic       btnr,
   output logic       up_pulse,
   output logic       down_pulse,
   output logic       left_pulse,
   output logic       right_pulse,
   output logic [3:0] btn_db
);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      PRESS_WAIT = 2'd1,
      PRESSED    = 2'd2,
      REL_WAIT   = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [3:0] w_raw;
   logic [3:0] r_sync1;
   logic [3:0] r_sync2;
   logic [3:0] w_pulse;
   logic [3:0] w_db;

   assign w_raw = {btnr, btnl, btnd, btnu};

   // Two-flop synchronizer for all four raw buttons.
   always_ff @(posedge clk) begin
      if (btnc) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= w_raw;
         r_sync2 <= r_sync1;
      end
   end

   for (genvar g = 0; g < 4; g++) begin : g_ch
      state_t           r_state;
      state_t           w_state_nxt;
      logic [CNT_W-1:0] r_cnt;
      logic [CNT_W-1:0] w_cnt_nxt;
      logic             r_pulse;
      logic             w_pulse_nxt;
      logic             w_s;

      assign w_s = r_sync2[g];

      // Next-state, counter and pulse decode for one channel.
      always_comb begin
         w_state_nxt = r_state;
         w_cnt_nxt   = r_cnt;
         w_pulse_nxt = 1'b0;
         unique case (r_state)
            IDLE: begin
               if (w_s) begin
                  w_state_nxt = PRESS_WAIT;
                  w_cnt_nxt   = '0;
               end
            end
            PRESS_WAIT: begin
               if (!w_s) begin
                  w_state_nxt = IDLE;
               end else if (r_cnt == CNT_LAST) begin
                  w_state_nxt = PRESSED;
                  w_pulse_nxt = 1'b1;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
            PRESSED: begin
               if (!w_s) begin
                  w_state_nxt = REL_WAIT;
                  w_cnt_nxt   = '0;
               end
            end
            REL_WAIT: begin
               // A release bounce returns to PRESSED without a new pulse.
               if (w_s) begin
                  w_state_nxt = PRESSED;
               end else if (r_cnt == CNT_LAST) begin
                  w_state_nxt = IDLE;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
            default: begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
            end
         endcase
      end

      // State, counter and pulse registers for one channel.
      always_ff @(posedge clk) begin
         if (btnc) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_pulse <= 1'b0;
         end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pulse <= w_pulse_nxt;
         end
      end

      assign w_pulse[g] = r_pulse;
      assign w_db[g]    = (r_state == PRESSED) || (r_state == REL_WAIT);
   end

   assign up_pulse    = w_pulse[0];
   assign down_pulse  = w_pulse[1];
   assign left_pulse  = w_pulse[2];
   assign right_pulse = w_pulse[3];
   assign btn_db      = w_db;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed testbench for button_conditioner with DEBOUNCE_CYCLES=4.
// Inputs change on the falling edge; outputs are sampled 1 ns after each rising edge.
// Edge index k is the rising edge that follows the negedge where the stimulus changed.
module tb_button_conditioner;

   logic       clk = 1'b0;
   logic       btnc, btnu, btnd, btnl, btnr;
   logic       up_pulse, down_pulse, left_pulse, right_pulse;
   logic [3:0] btn_db;

   int checks = 0;
   int errors = 0;

   button_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
      .clk(clk), .btnc(btnc), .btnu(btnu), .btnd(btnd), .btnl(btnl), .btnr(btnr),
      .up_pulse(up_pulse), .down_pulse(down_pulse), .left_pulse(left_pulse),
      .right_pulse(right_pulse), .btn_db(btn_db)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         btnu = 0; btnd = 0; btnl = 0; btnr = 0;
      end
   endtask

   task automatic test_reset();
      int npulse;
      btnc = 1; btnu = 0; btnd = 0; btnl = 0; btnr = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         btnu = ~btnu;
         step();
         checks++;
         if ({up_pulse, down_pulse, left_pulse, right_pulse, btn_db} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs k=%0d got=%b exp=00000000", k,
                     {up_pulse, down_pulse, left_pulse, right_pulse, btn_db});
         end
      end
      npulse = 0;
      @(negedge clk);
      btnc = 0; btnu = 1;
      for (int k = 0; k < 16; k++) begin
         if (k > 0) @(negedge clk);
         step();
         if (up_pulse === 1'b1) npulse++;
         checks++;
         if (up_pulse !== (k == 6)) begin
            errors++;
            $display("FAIL reset_held_pulse k=%0d got=%b exp=%b", k, up_pulse, (k == 6));
         end
      end
      checks++;
      if (npulse != 1) begin
         errors++;
         $display("FAIL reset_held_count got=%0d exp=1", npulse);
      end
      idle_cycles(12);
   endtask

   task automatic test_clean_press();
      @(negedge clk);
      btnu = 1;
      for (int k = 0; k < 20; k++) begin
         if (k > 0) @(negedge clk);
         step();
         checks++;
         if (up_pulse !== (k == 6) || btn_db[0] !== (k >= 6)) begin
            errors++;
            $display("FAIL clean_press k=%0d got pulse=%b db=%b exp pulse=%b db=%b",
                     k, up_pulse, btn_db[0], (k == 6), (k >= 6));
         end
      end
      @(negedge clk);
      btnu = 0;
      for (int k = 0; k < 12; k++) begin
         if (k > 0) @(negedge clk);
         step();
         checks++;
         if (up_pulse !== 1'b0 || btn_db[0] !== (k < 6)) begin
            errors++;
            $display("FAIL clean_release k=%0d got pulse=%b db=%b exp pulse=0 db=%b",
                     k, up_pulse, btn_db[0], (k < 6));
         end
      end
      idle_cycles(4);
   endtask

   task automatic test_bouncy_press();
      logic [7:0] pat;
      int npulse;
      pat = 8'b0011_0011;   // bit j = raw value before edge j (1,1,0,0,1,1,0,0)
      npulse = 0;
      for (int j = 0; j < 26; j++) begin
         @(negedge clk);
         btnd = (j < 8) ? pat[j] : 1'b1;
         step();
         if (down_pulse === 1'b1) npulse++;
         checks++;
         if (down_pulse !== (j == 14)) begin
            errors++;
            $display("FAIL bouncy_pulse j=%0d got=%b exp=%b", j, down_pulse, (j == 14));
         end
      end
      checks++;
      if (npulse != 1) begin
         errors++;
         $display("FAIL bouncy_count got=%0d exp=1", npulse);
      end
      idle_cycles(12);
   endtask

   task automatic test_glitch();
      for (int len = 3; len <= 4; len++) begin
         for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            btnl = (k < len);
            step();
            checks++;
            if (left_pulse !== 1'b0 || btn_db[2] !== 1'b0) begin
               errors++;
               $display("FAIL glitch len=%0d k=%0d got pulse=%b db=%b exp pulse=0 db=0",
                        len, k, left_pulse, btn_db[2]);
            end
         end
      end
      idle_cycles(4);
   endtask

   task automatic test_release_bounce();
      int npulse;
      npulse = 0;
      for (int j = 0; j < 24; j++) begin
         @(negedge clk);
         btnr = !(j == 7 || j == 8);
         step();
         if (right_pulse === 1'b1) npulse++;
         checks++;
         if (right_pulse !== (j == 6) || btn_db[3] !== (j >= 6)) begin
            errors++;
            $display("FAIL release_bounce j=%0d got pulse=%b db=%b exp pulse=%b db=%b",
                     j, right_pulse, btn_db[3], (j == 6), (j >= 6));
         end
      end
      checks++;
      if (npulse != 1) begin
         errors++;
         $display("FAIL release_bounce_count got=%0d exp=1", npulse);
      end
      idle_cycles(12);
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      btnu = 1; btnr = 1;
      for (int k = 0; k < 12; k++) begin
         if (k > 0) @(negedge clk);
         step();
         checks++;
         if (up_pulse !== (k == 6) || right_pulse !== (k == 6)) begin
            errors++;
            $display("FAIL simultaneous k=%0d got up=%b right=%b exp both=%b",
                     k, up_pulse, right_pulse, (k == 6));
         end
      end
      // btnd enters PRESS_WAIT at edge 2; reset lands at edge 4
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         btnd = 1;
         btnc = (k >= 4);
         step();
         checks++;
         if (down_pulse !== 1'b0) begin
            errors++;
            $display("FAIL midreset_pulse k=%0d got=%b exp=0", k, down_pulse);
         end
         if (k >= 4) begin
            checks++;
            if (btn_db !== 4'b0000 || up_pulse !== 1'b0 || right_pulse !== 1'b0) begin
               errors++;
               $display("FAIL midreset_db k=%0d got db=%b up=%b right=%b exp db=0000 up=0 right=0",
                        k, btn_db, up_pulse, right_pulse);
            end
         end
      end
      @(negedge clk);
      btnc = 0; btnu = 0; btnd = 0; btnr = 0;
      for (int k = 0; k < 12; k++) begin
         if (k > 0) @(negedge clk);
         step();
         checks++;
         if (down_pulse !== 1'b0 || btn_db !== 4'b0000) begin
            errors++;
            $display("FAIL postreset k=%0d got pulse=%b db=%b exp pulse=0 db=0000",
                     k, down_pulse, btn_db);
         end
      end
   endtask

   initial begin
      btnc = 1; btnu = 0; btnd = 0; btnl = 0; btnr = 0;
      test_reset();
      test_clean_press();
      test_bouncy_press();
      test_glitch();
      test_release_bounce();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
